// File: rtl/counter_scheduler.sv
// Round-robin arbiter that shares one 3-bit down-counter among NUM_REQ requesters.
// Optional RUN watchdog with err pulse: define COUNT_SCHED_TIMEOUT_EN.
module counter_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [3*NUM_REQ-1:0] req_val,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id,
  output logic                 cnt_load,
  output logic [2:0]           cnt_to,
  output logic                 cnt_en,
  input  logic                 cnt_done,
  output logic                 err
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    ACK
  } state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     rr_q, rr_d;
  logic [NUM_REQ-1:0] ack_d;
  logic               busy_d;
  logic [IDW-1:0]     grant_d;
  logic               load_d;
  logic [2:0]         to_d;
  logic               en_d;
  logic               found;
  logic [IDW-1:0]     win;
  logic [2:0]         win_val;

  // lowest offset from rr_q wins; descending scan lets it overwrite last
  always_comb begin
    found   = 1'b0;
    win     = rr_q;
    win_val = 3'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      int k;
      k = int'(rr_q) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (req[k]) begin
        found   = 1'b1;
        win     = k[IDW-1:0];
        win_val = req_val[3*k +: 3];
      end
    end
  end

`ifdef COUNT_SCHED_TIMEOUT_EN
  logic [3:0] wd_q, wd_d;
  logic       err_d;
`endif

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    ack_d   = '0;
    busy_d  = busy;
    grant_d = grant_id;
    load_d  = 1'b0;
    to_d    = cnt_to;
    en_d    = 1'b0;
`ifdef COUNT_SCHED_TIMEOUT_EN
    wd_d    = wd_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = LOAD;
          grant_d = win;
          to_d    = win_val;
          load_d  = 1'b1;
          busy_d  = 1'b1;
`ifdef COUNT_SCHED_TIMEOUT_EN
          wd_d    = 4'd0;
`endif
        end
      end
      LOAD: begin
        state_d = RUN;
        en_d    = 1'b1;
      end
      RUN: begin
        if (cnt_done) begin
          state_d         = ACK;
          ack_d[grant_id] = 1'b1;
`ifdef COUNT_SCHED_TIMEOUT_EN
        end else if (wd_q == 4'd11) begin
          state_d         = ACK;
          ack_d[grant_id] = 1'b1;
          err_d           = 1'b1;
        end else begin
          wd_d = wd_q + 4'd1;
          en_d = 1'b1;
`else
        end else begin
          en_d = 1'b1;
`endif
        end
      end
      ACK: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (grant_id == IDW'(NUM_REQ - 1)) rr_d = '0;
        else rr_d = grant_id + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      ack      <= '0;
      busy     <= 1'b0;
      grant_id <= '0;
      cnt_load <= 1'b0;
      cnt_to   <= 3'd0;
      cnt_en   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      ack      <= ack_d;
      busy     <= busy_d;
      grant_id <= grant_d;
      cnt_load <= load_d;
      cnt_to   <= to_d;
      cnt_en   <= en_d;
    end
  end

`ifdef COUNT_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_q <= 4'd0;
      err  <= 1'b0;
    end else begin
      wd_q <= wd_d;
      err  <= err_d;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
